crc_bus_master: RTL and testbench

Bus initiator that drives the memory-mapped CRC engine across the shared Sel/RW/addr/data_wr/data_rd interface. It takes one job per start: CTRL word, polynomial, seed and a stream of 32-bit data words. It programs the engine, streams the data, reads back the checksum and returns it to the requesting NoC-side logic, so software or a packet path no longer bit-bangs CRC registers.

---
 rtl/crc_pkg.sv | 35 +++
 rtl/crc_bus_master.sv | 179 +++++++++++++++++
 tb/tb_crc_bus_master.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC engine bus master.
// - Register offsets of the memory-mapped CRC engine relative to its base.
// - CTRL bit positions (TOT, TOTR, FXOR, WAS, TCRC).
// - Bus-master state enumeration and a helper that forces the WAS bit.
package crc_pkg;

  localparam logic [31:0] DATA_OFS  = 32'h0000_0000;
  localparam logic [31:0] GPOLY_OFS = 32'h0000_0004;
  localparam logic [31:0] CTRL_OFS  = 32'h0000_0008;

  localparam int unsigned TOT_LSB  = 30;  // TOT[31:30]
  localparam int unsigned TOTR_LSB = 28;  // TOTR[29:28]
  localparam int unsigned FXOR_BIT = 26;
  localparam int unsigned WAS_BIT  = 25;
  localparam int unsigned TCRC_BIT = 24;

  localparam logic [31:0] WAS_MASK = 32'h0000_0001 << WAS_BIT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_GPOLY,
    ST_W_CSEED,
    ST_W_SEED,
    ST_W_CDATA,
    ST_STREAM,
    ST_RD,
    ST_DONE
  } state_e;

  // CTRL value with WAS forced; every other bit passes through untouched.
  function automatic logic [31:0] ctrl_with_was(input logic [31:0] ctrl, input logic was);
    return was ? (ctrl | WAS_MASK) : (ctrl & ~WAS_MASK);
  endfunction

endpackage

// File: rtl/crc_bus_master.sv
// Bus initiator for the memory-mapped CRC engine.
// Takes one job per start: programs GPOLY, writes CTRL with WAS=1, writes the
// seed, rewrites CTRL with WAS=0, streams the data words, reads the checksum
// back and returns it with a one-cycle done pulse.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     job request, sampled only in IDLE
//   cfg_ctrl/gpoly/seed       job configuration, captured at start
//   in_valid/in_data/in_last  data word stream; in_ready accepts a word
//   busy, done, result        job status, completion pulse, checksum (held)
//   Sel, RW, addr, data_wr    registered bus outputs (RW: 1=write, 0=read)
//   data_rd                   bus read data from the responder
module crc_bus_master
  import crc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] cfg_ctrl,
  input  logic [DW-1:0] cfg_gpoly,
  input  logic [DW-1:0] cfg_seed,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          Sel,
  output logic          RW,
  output logic [31:0]   addr,
  output logic [DW-1:0] data_wr,
  input  logic [DW-1:0] data_rd
);

  state_e        state_q, state_d;
  logic [DW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] gpoly_q, gpoly_d;
  logic [DW-1:0] seed_q, seed_d;
  logic          sel_q, sel_d;
  logic          rw_q, rw_d;
  logic [31:0]   addr_q, addr_d;
  logic [DW-1:0] data_wr_q, data_wr_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] result_q, result_d;

  // The bus outputs are registered, so each arm computes the bus cycle of the
  // state being entered. In STREAM, in_ready_q=0 marks the final data write
  // cycle after the in_last word was accepted.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    gpoly_d    = gpoly_q;
    seed_d     = seed_q;
    sel_d      = 1'b0;
    rw_d       = 1'b0;
    addr_d     = '0;
    data_wr_d  = '0;
    in_ready_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ctrl_d    = cfg_ctrl;
          gpoly_d   = cfg_gpoly;
          seed_d    = cfg_seed;
          busy_d    = 1'b1;
          state_d   = ST_W_GPOLY;
          sel_d     = 1'b1;
          rw_d      = 1'b1;
          addr_d    = BASE_ADDR + GPOLY_OFS;
          data_wr_d = cfg_gpoly;
        end
      end
      ST_W_GPOLY: begin
        state_d   = ST_W_CSEED;
        sel_d     = 1'b1;
        rw_d      = 1'b1;
        addr_d    = BASE_ADDR + CTRL_OFS;
        data_wr_d = ctrl_with_was(ctrl_q, 1'b1);
      end
      ST_W_CSEED: begin
        state_d   = ST_W_SEED;
        sel_d     = 1'b1;
        rw_d      = 1'b1;
        addr_d    = BASE_ADDR + DATA_OFS;
        data_wr_d = seed_q;
      end
      ST_W_SEED: begin
        state_d   = ST_W_CDATA;
        sel_d     = 1'b1;
        rw_d      = 1'b1;
        addr_d    = BASE_ADDR + CTRL_OFS;
        data_wr_d = ctrl_with_was(ctrl_q, 1'b0);
      end
      ST_W_CDATA: begin
        state_d    = ST_STREAM;
        in_ready_d = 1'b1;
      end
      ST_STREAM: begin
        if (in_ready_q) begin
          in_ready_d = 1'b1;
          if (in_valid) begin
            sel_d      = 1'b1;
            rw_d       = 1'b1;
            addr_d     = BASE_ADDR + DATA_OFS;
            data_wr_d  = in_data;
            in_ready_d = !in_last;
          end
        end else begin
          state_d = ST_RD;
          sel_d   = 1'b1;
          rw_d    = 1'b0;
          addr_d  = BASE_ADDR + DATA_OFS;
        end
      end
      ST_RD: begin
        result_d = data_rd;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      gpoly_q    <= '0;
      seed_q     <= '0;
      sel_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_wr_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      gpoly_q    <= gpoly_d;
      seed_q     <= seed_d;
      sel_q      <= sel_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_wr_q  <= data_wr_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign Sel      = sel_q;
  assign RW       = rw_q;
  assign addr     = addr_q;
  assign data_wr  = data_wr_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_crc_bus_master.sv
// Testbench for crc_bus_master: a behavioural CRC engine answers the bus,
// a bus-trace log records every write, and results are compared against a
// direct CRC computation from the job parameters.
module tb_crc_bus_master;

  localparam logic [31:0] BASE = 32'h4003_2000;
  localparam logic [31:0] WASM = 32'h0200_0000;

  logic        clk, rst, start, in_valid, in_last, in_ready, busy, done, Sel, RW;
  logic [31:0] cfg_ctrl, cfg_gpoly, cfg_seed, in_data, result, addr, data_wr, data_rd;
  int checks, failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc_bus_master #(.BASE_ADDR(BASE), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_ctrl(cfg_ctrl), .cfg_gpoly(cfg_gpoly), .cfg_seed(cfg_seed),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .busy(busy), .done(done), .result(result),
    .Sel(Sel), .RW(RW), .addr(addr), .data_wr(data_wr), .data_rd(data_rd)
  );

  // ---------------- CRC arithmetic ----------------
  function automatic logic [31:0] xpose(input logic [31:0] v, input logic [1:0] m);
    logic [31:0] r;
    r = v;
    case (m)
      2'd1: for (int i = 0; i < 32; i++) r[i] = v[(i / 8) * 8 + 7 - (i % 8)];
      2'd2: for (int i = 0; i < 32; i++) r[i] = v[31 - i];
      2'd3: r = {v[7:0], v[15:8], v[23:16], v[31:24]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] wmask(input logic [31:0] ctrl);
    return ctrl[24] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // MSB-first polynomial division of one 32-bit word.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] d,
                                           input logic [31:0] poly, input logic wide);
    logic [31:0] c;
    logic fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (wide) begin
        fb = c[31] ^ d[i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ poly;
      end else begin
        fb = c[15] ^ d[i];
        c  = {16'h0, c[14:0], 1'b0};
        if (fb) c = c ^ {16'h0, poly[15:0]};
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_ref(input logic [31:0] ctrl, input logic [31:0] poly,
                                          input logic [31:0] seed, input logic [31:0] w[8],
                                          input int n);
    logic [31:0] c;
    c = xpose(seed, ctrl[31:30]) & wmask(ctrl);
    for (int k = 0; k < n; k++) c = crc_step(c, xpose(w[k], ctrl[31:30]), poly, ctrl[24]);
    if (ctrl[26]) c = c ^ wmask(ctrl);
    return xpose(c, ctrl[29:28]);
  endfunction

  // ---------------- engine responder + bus monitor ----------------
  logic [31:0] eng_poly, eng_ctrl, eng_crc, eng_out;
  logic [31:0] wa_q[$], wd_q[$];
  int wi_q[$];
  int edge_n, sel_cnt, rd_cnt, done_cnt;

  initial begin
    edge_n = 0; sel_cnt = 0; rd_cnt = 0; done_cnt = 0;
    eng_poly = '0; eng_ctrl = '0; eng_crc = '0;
  end

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst) begin
      if (done) done_cnt <= done_cnt + 1;
      if (Sel) sel_cnt <= sel_cnt + 1;
      if (Sel && !RW) rd_cnt <= rd_cnt + 1;
      if (Sel && RW) begin
        wa_q.push_back(addr);
        wd_q.push_back(data_wr);
        wi_q.push_back(edge_n);
        if (addr == BASE + 32'h4) eng_poly <= data_wr;
        else if (addr == BASE + 32'h8) eng_ctrl <= data_wr;
        else if (addr == BASE) begin
          if (eng_ctrl[25]) eng_crc <= xpose(data_wr, eng_ctrl[31:30]) & wmask(eng_ctrl);
          else eng_crc <= crc_step(eng_crc, xpose(data_wr, eng_ctrl[31:30]), eng_poly, eng_ctrl[24]);
        end
      end
    end
  end

  always_comb begin
    eng_out = xpose(eng_crc ^ (eng_ctrl[26] ? wmask(eng_ctrl) : 32'h0), eng_ctrl[29:28]);
    data_rd = (Sel && !RW && addr == BASE) ? eng_out : 32'hBAD0_BAD0;
  end

  // ---------------- job driver ----------------
  int job_t0, job_q0, job_sel0, job_rd0, job_lat;
  logic [31:0] job_res;
  logic job_busy_at_done;

  task automatic run_job(input logic [31:0] ctrl, input logic [31:0] gpoly, input logic [31:0] seed,
                         input logic [31:0] w[8], input int g[8], input int n);
    int b;
    job_lat = -1;
    job_res = 32'hx;
    job_busy_at_done = 1'bx;
    @(negedge clk);
    job_q0 = wa_q.size(); job_sel0 = sel_cnt; job_rd0 = rd_cnt; job_t0 = edge_n;
    cfg_ctrl = ctrl; cfg_gpoly = gpoly; cfg_seed = seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < g[k]; j++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = w[k]; in_last = (k == n - 1);
      b = 0;
      while (in_ready !== 1'b1 && b < 40) begin
        @(negedge clk);
        b++;
      end
      if (in_ready !== 1'b1) begin
        checks++; failures++;
        $display("FAIL handshake_timeout word=%0d in_ready=%b required=1", k, in_ready);
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    b = 0;
    while (done !== 1'b1 && b < 60) begin
      @(negedge clk);
      b++;
    end
    if (done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL done_timeout done=%b required=1", done);
      return;
    end
    job_lat = edge_n - job_t0 - 1;
    job_res = result;
    job_busy_at_done = busy;
    @(negedge clk);
  endtask

  // Count of deviations of the logged bus activity from the expected sequence.
  function automatic int trace_errors(input logic [31:0] ctrl, input logic [31:0] gpoly,
                                      input logic [31:0] seed, input logic [31:0] w[8],
                                      input int g[8], input int n);
    int e, gs, ei;
    logic [31:0] ea, ed;
    e = 0; gs = 0;
    if (wa_q.size() != job_q0 + 4 + n) e++;
    if (sel_cnt - job_sel0 != 5 + n) e++;
    if (rd_cnt - job_rd0 != 1) e++;
    for (int i = 0; i < 4 + n && job_q0 + i < wa_q.size(); i++) begin
      case (i)
        0: begin ea = BASE + 32'h4; ed = gpoly;         ei = job_t0 + 1; end
        1: begin ea = BASE + 32'h8; ed = ctrl | WASM;   ei = job_t0 + 2; end
        2: begin ea = BASE;         ed = seed;          ei = job_t0 + 3; end
        3: begin ea = BASE + 32'h8; ed = ctrl & ~WASM;  ei = job_t0 + 4; end
        default: begin
          gs += g[i - 4];
          ea = BASE; ed = w[i - 4]; ei = job_t0 + 6 + (i - 4) + gs;
        end
      endcase
      if (wa_q[job_q0 + i] !== ea || wd_q[job_q0 + i] !== ed || wi_q[job_q0 + i] != ei) e++;
    end
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({Sel, RW, in_ready, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=00000", {Sel, RW, in_ready, busy, done});
    end
    checks++;
    if (addr !== 32'h0 || data_wr !== 32'h0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs addr=%h data_wr=%h result=%h required=0", addr, data_wr, result);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Sel, in_ready, busy} !== 3'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b required=000", {Sel, in_ready, busy});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_tcrc32();
    logic [31:0] w[8];
    int g[8];
    logic [31:0] c1;
    w = '{default: 32'h0}; g = '{default: 0};
    run_job(32'h0100_0000, 32'h04C1_1DB7, 32'h0, w, g, 1);
    checks++;
    if (job_res !== 32'h0000_0000) begin
      failures++; $display("FAIL tcrc32_result got=%h required=00000000", job_res);
    end
    checks++;
    if (job_lat != 7) begin
      failures++; $display("FAIL tcrc32_latency got=%0d required=7", job_lat);
    end
    c1 = (wd_q.size() > job_q0 + 1) ? wd_q[job_q0 + 1] : 32'hx;
    checks++;
    if (c1 !== 32'h0300_0000) begin
      failures++; $display("FAIL tcrc32_ctrl_was got=%h required=03000000", c1);
    end
    checks++;
    if (trace_errors(32'h0100_0000, 32'h04C1_1DB7, 32'h0, w, g, 1) != 0) begin
      failures++;
      $display("FAIL tcrc32_trace errors=%0d required=0",
               trace_errors(32'h0100_0000, 32'h04C1_1DB7, 32'h0, w, g, 1));
    end
    checks++;
    if (job_busy_at_done !== 1'b0) begin
      failures++; $display("FAIL busy_in_done got=%b required=0", job_busy_at_done);
    end
  endtask

  task automatic test_fxor();
    logic [31:0] w[8];
    int g[8];
    w = '{default: 32'h0}; g = '{default: 0};
    run_job(32'h0500_0000, 32'h04C1_1DB7, 32'h0, w, g, 1);
    checks++;
    if (job_res !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL fxor_result got=%h required=ffffffff", job_res);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (result !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL result_hold got=%h required=ffffffff", result);
    end
  endtask

  task automatic test_crc16_back_to_back();
    logic [31:0] w[8];
    int g[8];
    int d;
    w = '{default: 32'h0}; g = '{default: 0};
    w[0] = 32'h3132_3334; w[1] = 32'h3536_3738;
    run_job(32'h0, 32'h0000_1021, 32'h0000_FFFF, w, g, 2);
    checks++;
    if (job_res !== crc_ref(32'h0, 32'h0000_1021, 32'h0000_FFFF, w, 2)) begin
      failures++;
      $display("FAIL crc16_result got=%h required=%h", job_res,
               crc_ref(32'h0, 32'h0000_1021, 32'h0000_FFFF, w, 2));
    end
    d = (wi_q.size() > job_q0 + 5) ? wi_q[job_q0 + 5] - wi_q[job_q0 + 4] : -1;
    checks++;
    if (d != 1) begin
      failures++; $display("FAIL crc16_consecutive got=%0d required=1", d);
    end
    checks++;
    if (trace_errors(32'h0, 32'h0000_1021, 32'h0000_FFFF, w, g, 2) != 0) begin
      failures++; $display("FAIL crc16_trace errors=%0d required=0",
                           trace_errors(32'h0, 32'h0000_1021, 32'h0000_FFFF, w, g, 2));
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w[8];
    int g[8];
    logic [31:0] ctrl, poly, seed, r0;
    int l0, te0, te1;
    w = '{default: 32'h0}; g = '{default: 0};
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    ctrl = $urandom; poly = $urandom; seed = $urandom;
    run_job(ctrl, poly, seed, w, g, 4);
    r0 = job_res; l0 = job_lat;
    te0 = trace_errors(ctrl, poly, seed, w, g, 4);
    g = '{0, 0, 1, 3, 0, 0, 0, 0};
    run_job(ctrl, poly, seed, w, g, 4);
    te1 = trace_errors(ctrl, poly, seed, w, g, 4);
    checks++;
    if (job_res !== r0 || r0 !== crc_ref(ctrl, poly, seed, w, 4)) begin
      failures++;
      $display("FAIL gaps_result gapped=%h gapless=%h required=%h", job_res, r0,
               crc_ref(ctrl, poly, seed, w, 4));
    end
    checks++;
    if (te0 != 0 || te1 != 0) begin
      failures++; $display("FAIL gaps_trace gapless_err=%0d gapped_err=%0d required=0", te0, te1);
    end
    checks++;
    if (l0 != 10 || job_lat != 14) begin
      failures++; $display("FAIL gaps_latency gapless=%0d gapped=%0d required=10/14", l0, job_lat);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w[8];
    int g[8];
    logic [31:0] ctrl, poly, seed;
    int dc0, sc0, bad;
    w = '{default: 32'h0}; g = '{default: 0};
    for (int k = 0; k < 3; k++) w[k] = $urandom;
    ctrl = $urandom; poly = $urandom; seed = $urandom;
    dc0 = done_cnt;
    fork
      run_job(ctrl, poly, seed, w, g, 3);
      begin
        int b;
        b = 0;
        while (in_ready !== 1'b1 && b < 40) begin @(negedge clk); b++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (done !== 1'b1 && b < 60) begin @(negedge clk); b++; end
        if (done === 1'b1) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    checks++;
    if (job_res !== crc_ref(ctrl, poly, seed, w, 3)) begin
      failures++; $display("FAIL start_ignored_result got=%h required=%h", job_res,
                           crc_ref(ctrl, poly, seed, w, 3));
    end
    checks++;
    if (trace_errors(ctrl, poly, seed, w, g, 3) != 0) begin
      failures++; $display("FAIL start_ignored_trace errors=%0d required=0",
                           trace_errors(ctrl, poly, seed, w, g, 3));
    end
    sc0 = sel_cnt; bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b0 || Sel !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || sel_cnt != sc0 || done_cnt - dc0 != 1) begin
      failures++;
      $display("FAIL no_restart busy_sel_cycles=%0d sel_delta=%0d dones=%0d required=0/0/1",
               bad, sel_cnt - sc0, done_cnt - dc0);
    end
    run_job(ctrl ^ 32'h0100_0000, poly, seed, w, g, 3);
    checks++;
    if (job_res !== crc_ref(ctrl ^ 32'h0100_0000, poly, seed, w, 3)) begin
      failures++; $display("FAIL represent_start got=%h required=%h", job_res,
                           crc_ref(ctrl ^ 32'h0100_0000, poly, seed, w, 3));
    end
  endtask

  task automatic test_reset_mid_stream();
    int b, dc0;
    @(negedge clk);
    cfg_ctrl = 32'h0100_0000; cfg_gpoly = 32'h04C1_1DB7; cfg_seed = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = $urandom;
    b = 0;
    while (in_ready !== 1'b1 && b < 40) begin @(negedge clk); b++; end
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    checks++;
    if (Sel !== 1'b1) begin
      failures++; $display("FAIL midstream_sel_before got=%b required=1", Sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({Sel, busy, in_ready, done} !== 4'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL midstream_reset flags=%b result=%h required=0000/0", {Sel, busy, in_ready, done}, result);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != dc0 || busy !== 1'b0 || Sel !== 1'b0) begin
      failures++;
      $display("FAIL midstream_no_done dones=%0d busy=%b Sel=%b required=0/0/0", done_cnt - dc0, busy, Sel);
    end
  endtask

  task automatic test_random();
    logic [31:0] w[8];
    int g[8];
    logic [31:0] ctrl, poly, seed;
    int n, gsum;
    for (int t = 0; t < 5; t++) begin
      w = '{default: 32'h0}; g = '{default: 0};
      n = $urandom_range(1, 6);
      gsum = 0;
      for (int k = 0; k < n; k++) begin
        w[k] = $urandom;
        if (k > 0) g[k] = $urandom_range(0, 2);
        gsum += g[k];
      end
      ctrl = $urandom; poly = $urandom; seed = $urandom;
      run_job(ctrl, poly, seed, w, g, n);
      checks++;
      if (job_res !== crc_ref(ctrl, poly, seed, w, n)) begin
        failures++; $display("FAIL random_result job=%0d got=%h required=%h", t, job_res,
                             crc_ref(ctrl, poly, seed, w, n));
      end
      checks++;
      if (trace_errors(ctrl, poly, seed, w, g, n) != 0 || job_lat != 6 + n + gsum) begin
        failures++;
        $display("FAIL random_trace job=%0d errors=%0d latency=%0d required=0/%0d", t,
                 trace_errors(ctrl, poly, seed, w, g, n), job_lat, 6 + n + gsum);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    cfg_ctrl = '0; cfg_gpoly = '0; cfg_seed = '0;
    test_reset();
    test_tcrc32();
    test_fxor();
    test_crc16_back_to_back();
    test_gaps();
    test_start_ignored();
    test_reset_mid_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
